// File: rtl/cascade_counter.sv
// Two-stage counter: a modulo-MODULUS primary stage that cascades into a free-wrapping secondary stage.
// Optional capture registers are enabled by defining CASCADE_CAPTURE_EN.
module cascade_counter #(
  parameter int WIDTH   = 4,
  parameter int WIDTH2  = 4,
  parameter int MODULUS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              up_down,
  input  logic              saturate,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
`ifdef CASCADE_CAPTURE_EN
  input  logic              capture,
  output logic [WIDTH-1:0]  cap_out,
  output logic [WIDTH2-1:0] cap2_out,
`endif
  output logic [WIDTH-1:0]  counter_out,
  output logic [WIDTH2-1:0] counter2_out,
  output logic              tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

  always_ff @(posedge clock) begin
    if (reset) begin
      counter_out  <= '0;
      counter2_out <= '0;
      tc           <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        counter_out <= load_clamped;
      end else if (enable) begin
        if (up_down) begin
          if (counter_out < MAX_VAL) begin
            counter_out <= counter_out + 1'b1;
          end else if (!saturate) begin
            counter_out  <= '0;
            counter2_out <= counter2_out + 1'b1;
            tc           <= 1'b1;
          end
        end else begin
          if (counter_out != '0) begin
            counter_out <= counter_out - 1'b1;
          end else if (!saturate) begin
            counter_out  <= MAX_VAL;
            counter2_out <= counter2_out - 1'b1;
            tc           <= 1'b1;
          end
        end
      end
    end
  end

`ifdef CASCADE_CAPTURE_EN
  // Snapshot of the pre-edge counts; counting is unaffected by capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_out  <= '0;
      cap2_out <= '0;
    end else if (capture) begin
      cap_out  <= counter_out;
      cap2_out <= counter2_out;
    end
  end
`endif

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter (MODULUS=10): driver pushes model predictions, monitor pops and compares.
// Directed scenarios first, then randomized traffic.
module tb_cascade_counter;
  localparam int MOD = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       saturate = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] counter_out;
  logic [3:0] counter2_out;
  logic       tc;
`ifdef CASCADE_CAPTURE_EN
  logic       capture = 1'b0;
  logic [3:0] cap_out;
  logic [3:0] cap2_out;
`endif

  cascade_counter #(.WIDTH(4), .WIDTH2(4), .MODULUS(MOD)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .up_down      (up_down),
    .saturate     (saturate),
    .load         (load),
    .load_value   (load_value),
`ifdef CASCADE_CAPTURE_EN
    .capture      (capture),
    .cap_out      (cap_out),
    .cap2_out     (cap2_out),
`endif
    .counter_out  (counter_out),
    .counter2_out (counter2_out),
    .tc           (tc)
  );

  always #5 clock = ~clock;

  typedef struct {
    int c;
    int c2;
    int t;
    int k;
    int k2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state, in plain integers
  int m_c = 0, m_c2 = 0, m_tc = 0, m_k = 0, m_k2 = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("counter_out", int'(counter_out), e.c);
      check("counter2_out", int'(counter2_out), e.c2);
      check("tc", int'(tc), e.t);
`ifdef CASCADE_CAPTURE_EN
      check("cap_out", int'(cap_out), e.k);
      check("cap2_out", int'(cap2_out), e.k2);
`endif
    end
  end

  task automatic step(input bit r, input bit en, input bit ud, input bit sat,
                      input bit ld, input int lv, input bit cp);
    exp_t e;
    @(negedge clock);
    reset = r; enable = en; up_down = ud; saturate = sat; load = ld;
    load_value = 4'(lv);
`ifdef CASCADE_CAPTURE_EN
    capture = cp;
`endif
    if (r) begin
      m_c = 0; m_c2 = 0; m_tc = 0; m_k = 0; m_k2 = 0;
    end else begin
      if (cp) begin
        m_k = m_c; m_k2 = m_c2;
      end
      m_tc = 0;
      if (ld) begin
        m_c = (lv > MOD - 1) ? MOD - 1 : lv;
      end else if (en) begin
        if (ud) begin
          if (m_c < MOD - 1) m_c = m_c + 1;
          else if (!sat) begin m_c = 0; m_c2 = (m_c2 + 1) % 16; m_tc = 1; end
        end else begin
          if (m_c > 0) m_c = m_c - 1;
          else if (!sat) begin m_c = MOD - 1; m_c2 = (m_c2 + 15) % 16; m_tc = 1; end
        end
      end
    end
    e.c = m_c; e.c2 = m_c2; e.t = m_tc; e.k = m_k; e.k2 = m_k2;
    q.push_back(e);
  endtask

  initial begin
    // reset held with load and enable active
    step(1, 1, 1, 0, 1, 5, 0);
    step(1, 1, 1, 0, 1, 5, 0);
    // up wrap over a full cycle
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, 0);
    // reset then single down wrap
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // saturate up at top, then step down
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 8, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 0);
    // saturate down at zero
    step(0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 0);
    // load clamp, reset beats load, hold
    step(0, 1, 1, 0, 1, 12, 0);
    step(1, 1, 1, 0, 1, 12, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0);
    // capture while counting
    step(0, 0, 1, 0, 1, 7, 0);
    step(0, 1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 15)), 1'($urandom));
    end
    @(negedge clock);
    enable = 1'b0; load = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
